// File: rtl/dm_copy_pkg.sv
// Shared types and default widths for the data-memory copy engine.
//   AW : word-address width (memory depth 2**AW)
//   DW : data word width
//   LW : length width, AW+1 so a full-memory length fits
package dm_copy_pkg;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LW = 8;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} dm_copy_state_t;
  typedef enum logic {UP, DOWN} dm_copy_dir_t;
endpackage

// File: rtl/dm_copy_addr_gen.sv
// Source/destination pointer pair plus remaining-word counter.
//   clk, rst  : clock, async active-high reset
//   load      : capture src/dst/len and pick the copy direction
//   step      : advance both pointers one word and decrement the count
//   src, dst  : start word addresses
//   len       : word count, already clamped and non-zero when load=1
//   sptr_new  : source pointer as it will be after this edge (load or step)
//   dptr      : current destination pointer
//   last      : the word being written now is the final one
module dm_copy_addr_gen #(
  parameter int AW = dm_copy_pkg::AW,
  parameter int LW = dm_copy_pkg::LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] sptr_new,
  output logic [AW-1:0] dptr,
  output logic          last
);
  import dm_copy_pkg::*;

  dm_copy_dir_t  dir, dir_ld;
  logic [AW-1:0] sptr, diff, span;
  logic [AW-1:0] sptr_ld, dptr_ld, sptr_step, dptr_step;
  logic [LW-1:0] cnt;

  always_comb begin
    diff = dst - src;
    span = AW'(len - LW'(1));
    // Destination starts inside the source window (mod depth): walk from the
    // top end so no source word is overwritten before it is read.
    dir_ld    = ((dst != src) && (LW'(diff) < len)) ? DOWN : UP;
    sptr_ld   = (dir_ld == DOWN) ? src + span : src;
    dptr_ld   = (dir_ld == DOWN) ? dst + span : dst;
    sptr_step = (dir == DOWN) ? sptr - AW'(1) : sptr + AW'(1);
    dptr_step = (dir == DOWN) ? dptr - AW'(1) : dptr + AW'(1);
    sptr_new  = load ? sptr_ld : sptr_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir  <= UP;
      sptr <= '0;
      dptr <= '0;
      cnt  <= '0;
    end else if (load) begin
      dir  <= dir_ld;
      sptr <= sptr_ld;
      dptr <= dptr_ld;
      cnt  <= len;
    end else if (step) begin
      sptr <= sptr_step;
      dptr <= dptr_step;
      cnt  <= cnt - LW'(1);
    end
  end

  assign last = (cnt == LW'(1));
endmodule

// File: rtl/dm_copy_engine.sv
// Bus-master block copy (memmove semantics) inside the data memory.
//   clk, rst        : clock, async active-high reset
//   start           : 1-cycle request, honoured only in IDLE
//   src, dst, len   : copy parameters, sampled with start
//   busy            : high while words are being moved (RD/WR)
//   done            : 1-cycle completion pulse
//   dm_addr/rd/wr/wdata : memory port, all registered
//   dm_rdata        : memory read data, combinational from dm_addr
module dm_copy_engine #(
  parameter int AW = dm_copy_pkg::AW,
  parameter int DW = dm_copy_pkg::DW,
  parameter int LW = dm_copy_pkg::LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] dm_addr,
  output logic          dm_rd,
  output logic          dm_wr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);
  import dm_copy_pkg::*;

  localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

  dm_copy_state_t state;
  logic [LW-1:0]  len_c;
  logic [AW-1:0]  sptr_new, dptr;
  logic           load, step, last;

  assign len_c = (len > MAX_LEN) ? MAX_LEN : len;
  assign load  = (state == IDLE) && start && (len_c != '0);
  assign step  = (state == WR);

  dm_copy_addr_gen #(.AW(AW), .LW(LW)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .src      (src),
    .dst      (dst),
    .len      (len_c),
    .sptr_new (sptr_new),
    .dptr     (dptr),
    .last     (last)
  );

  // Outputs are set one edge ahead so they line up with the state they
  // belong to. dm_wdata doubles as the read-data latch: it captures the word
  // at the end of RD and is cleared again when WR ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dm_addr  <= '0;
      dm_rd    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_c == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= RD;
              busy    <= 1'b1;
              dm_rd   <= 1'b1;
              dm_addr <= sptr_new;
            end
          end
        end
        RD: begin
          state    <= WR;
          dm_rd    <= 1'b0;
          dm_wr    <= 1'b1;
          dm_addr  <= dptr;
          dm_wdata <= dm_rdata;
        end
        WR: begin
          dm_wr    <= 1'b0;
          dm_wdata <= '0;
          if (last) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            dm_addr <= '0;
          end else begin
            state   <= RD;
            dm_rd   <= 1'b1;
            dm_addr <= sptr_new;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
